// File: rtl/serial_magnitude_comparator_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_magnitude_comparator_if
//  Purpose  : Request/result bundle for the bit-serial magnitude comparator.
//             The master drives start and the operands. The slave returns
//             busy, the done strobe and the three result flags.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  modport master (
    output start, a, b,
    input  busy, done, a_gt_b, a_eq_b, a_lt_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_gt_b, a_eq_b, a_lt_b
  );
endinterface
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : serial_magnitude_comparator
//  Purpose  : Unsigned MSB-first bit-serial magnitude comparator. A start
//             pulse in IDLE latches both operands. One bit is scanned per
//             clock, and the result is reported as one of gt/eq/lt together
//             with a single-cycle done strobe.
//  Options  : SERIAL_CMP_EARLY_EXIT_EN - finish as soon as the first
//             differing bit is found. Equal operands still scan every bit.
//  Revision : 1.0  initial release
// ============================================================================
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);

  localparam int             IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic             decided_q, decided_d;
  logic             gt_q,      gt_d;
  logic             eq_q,      eq_d;
  logic             lt_q,      lt_d;

  // The operands shift left, so the bit under test always sits at the MSB.
  logic w_a_bit;
  logic w_b_bit;
  logic w_diff;

  assign w_a_bit = a_q[WIDTH-1];
  assign w_b_bit = b_q[WIDTH-1];
  assign w_diff  = w_a_bit ^ w_b_bit;

  // Next-state logic for the FSM, the operand shifters and the result flags.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          idx_d     = IDX_MAX;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          eq_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = S_COMPARE;
        end
      end

      S_COMPARE: begin
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        idx_d = idx_q - 1'b1;
        // Only the first differing bit decides. Lower bits are ignored.
        if (!decided_q && w_diff) begin
          decided_d = 1'b1;
          gt_d      = w_a_bit;
          lt_d      = w_b_bit;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          state_d   = S_DONE;
`endif
        end
        if (idx_q == '0) begin
          state_d = S_DONE;
          if (!decided_q && !w_diff) begin
            eq_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset aborts any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.busy   = (state_q == S_COMPARE) || (state_q == S_DONE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.a_gt_b = gt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_lt_b = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_magnitude_comparator
//  Purpose  : Self-checking bench for serial_magnitude_comparator, built
//             around a reference model that uses plain integer compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_magnitude_comparator;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference latency: edges from acceptance until done is visible.
  function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int k;
    logic [WIDTH-1:0] x;
    x = a ^ b;
    k = -1;
    for (int i = 0; i < WIDTH; i++) if (x[i]) k = i;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (k < 0) return WIDTH;
    return WIDTH - k;
`else
    return WIDTH;
`endif
  endfunction

  // Issue one compare. Report the busy level after E0, the edge count
  // until done, the flags seen during done, and whether busy cleared
  // one edge later.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic busy_e0, output int lat,
                         output logic gt, output logic eq, output logic lt,
                         output logic busy_after);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    busy_e0   = bus.busy;
    lat = -1; gt = 1'b0; eq = 1'b0; lt = 1'b0; busy_after = 1'b1;
    for (int n = 1; n <= WIDTH + 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        gt  = bus.a_gt_b;
        eq  = bus.a_eq_b;
        lt  = bus.a_lt_b;
        @(posedge clk);
        #1;
        busy_after = bus.busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.done, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus.busy, bus.done, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_gt();
    logic be, ba, gt, eq, lt; int lat;
    run_cmp(8'd37, 8'd12, be, lat, gt, eq, lt, ba);
    n_tests++;
    if (be !== 1'b1) begin n_fail++; $display("FAIL gt_busy_e0: got %b expected 1", be); end
    n_tests++;
    if (lat !== WIDTH) begin n_fail++; $display("FAIL gt_latency: got %0d expected %0d", lat, WIDTH); end
    n_tests++;
    if ({gt, eq, lt} !== 3'b100) begin n_fail++; $display("FAIL gt_flags: got %b expected 100", {gt, eq, lt}); end
    n_tests++;
    if (ba !== 1'b0) begin n_fail++; $display("FAIL gt_busy_after: got %b expected 0", ba); end
  endtask

  task automatic test_eq_hold();
    logic be, ba, gt, eq, lt; int lat;
    run_cmp(8'd63, 8'd63, be, lat, gt, eq, lt, ba);
    n_tests++;
    if (lat !== WIDTH || {gt, eq, lt} !== 3'b010) begin
      n_fail++; $display("FAIL eq_result: got lat %0d flags %b expected lat %0d flags 010", lat, {gt, eq, lt}, WIDTH);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b, bus.done} !== 4'b0100) begin
        n_fail++; $display("FAIL eq_hold cycle %0d: got %b expected 0100", i,
                           {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b, bus.done});
      end
    end
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_tests++;
    if ({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} !== 3'b000) begin
      n_fail++; $display("FAIL eq_clear_on_start: got %b expected 000", {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b});
    end
    repeat (WIDTH + 2) @(posedge clk);
  endtask

  task automatic test_ignore_start();
    logic be, ba, gt, eq, lt; int lat; int ndone;
    run_cmp(8'd0, 8'd63, be, lat, gt, eq, lt, ba);
    n_tests++;
    if ({gt, eq, lt} !== 3'b001) begin n_fail++; $display("FAIL lt_flags: got %b expected 001", {gt, eq, lt}); end
    // Keep start high through the whole busy window with different operands.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd0; bus.b = 8'd63;
    @(posedge clk); #1;
    bus.a = 8'd63; bus.b = 8'd0;
    ndone = 0; gt = 1'b0; eq = 1'b0; lt = 1'b0;
    for (int n = 1; n <= WIDTH + 1; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin ndone++; gt = bus.a_gt_b; eq = bus.a_eq_b; lt = bus.a_lt_b; end
    end
    bus.start = 1'b0;
    for (int n = 0; n < 2 * WIDTH; n++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_tests++;
    if (ndone !== 1) begin n_fail++; $display("FAIL ignore_start_done_count: got %0d expected 1", ndone); end
    n_tests++;
    if ({gt, eq, lt} !== 3'b001) begin n_fail++; $display("FAIL ignore_start_flags: got %b expected 001", {gt, eq, lt}); end
  endtask

  task automatic test_async_reset();
    logic be, ba, gt, eq, lt; int lat; int ndone;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd37; bus.b = 8'd12;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %b expected 00000",
                         {bus.busy, bus.done, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b});
    end
    ndone = 0;
    for (int n = 0; n < WIDTH; n++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    rst = 1'b0;
    for (int n = 0; n < WIDTH; n++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin n_fail++; $display("FAIL async_reset_no_done: got %0d done strobes expected 0", ndone); end
    run_cmp(8'd37, 8'd12, be, lat, gt, eq, lt, ba);
    n_tests++;
    if (lat !== WIDTH || {gt, eq, lt} !== 3'b100) begin
      n_fail++; $display("FAIL after_reset_cmp: got lat %0d flags %b expected lat %0d flags 100", lat, {gt, eq, lt}, WIDTH);
    end
  endtask

  task automatic test_early_exit();
    logic be, ba, gt, eq, lt; int lat; int el;
    run_cmp(8'h80, 8'h00, be, lat, gt, eq, lt, ba);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    el = 1;
`else
    el = WIDTH;
`endif
    n_tests++;
    if (lat !== el || {gt, eq, lt} !== 3'b100) begin
      n_fail++; $display("FAIL msb_diff: got lat %0d flags %b expected lat %0d flags 100", lat, {gt, eq, lt}, el);
    end
    run_cmp(8'h05, 8'h04, be, lat, gt, eq, lt, ba);
    n_tests++;
    if (lat !== WIDTH || {gt, eq, lt} !== 3'b100) begin
      n_fail++; $display("FAIL lsb_diff: got lat %0d flags %b expected lat %0d flags 100", lat, {gt, eq, lt}, WIDTH);
    end
  endtask

  task automatic test_random();
    logic be, ba, gt, eq, lt; int lat;
    logic [WIDTH-1:0] a, b;
    logic [2:0] exp_f;
    for (int i = 0; i < 60; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: b = a;
        1: begin a[7:6] = 2'b00; b = WIDTH'($urandom_range(0, 63)); end
        default: b = WIDTH'($urandom);
      endcase
      exp_f = (int'(a) > int'(b)) ? 3'b100 : ((int'(a) == int'(b)) ? 3'b010 : 3'b001);
      run_cmp(a, b, be, lat, gt, eq, lt, ba);
      n_tests++;
      if (lat !== exp_latency(a, b) || {gt, eq, lt} !== exp_f || be !== 1'b1 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL random a=%0d b=%0d: got lat %0d flags %b busy %b/%b expected lat %0d flags %b busy 1/0",
                 a, b, lat, {gt, eq, lt}, be, ba, exp_latency(a, b), exp_f);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    int ndone; logic [2:0] seen;
    // Raising start again right after done returns the block to IDLE exercises the earliest re-accept.
    for (int i = 0; i < 4; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      ndone = 0; seen = 3'b000;
      for (int n = 1; n <= WIDTH + 1; n++) begin
        @(posedge clk); #1;
        if (bus.done) begin ndone++; seen = {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b}; end
      end
      n_tests++;
      if (ndone !== 1 || seen !== ((a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001) || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL back_to_back %0d: got done %0d flags %b busy %b", i, ndone, seen, bus.busy);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_gt();
    test_eq_hold();
    test_ignore_start();
    test_async_reset();
    test_early_exit();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
